// File: rtl/dequantizer_pkg.sv
// Shared constants, stage records and result packing for the FP32 dequantizer.
package dequantizer_pkg;

  localparam int unsigned FP32_EXP_W   = 8;
  localparam int unsigned FP32_MAN_W   = 23;
  localparam logic [7:0]  FP32_EXP_MAX = 8'd255;

  localparam int unsigned IDX_W     = 8;
  localparam int unsigned IDX_SHIFT = 8;
  // Leading one of index*m sits at bit MAN_W+IDX_SHIFT when index/256 would be 1.0
  localparam int unsigned NORM_BASE = FP32_MAN_W + IDX_SHIFT;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic                  valid;
    logic [IDX_W-1:0]      idx;
    logic [FP32_EXP_W-1:0] e;
    logic [FP32_MAN_W:0]   m;
    logic                  zero;
    logic                  nan;
  } stage1_t;

  typedef struct packed {
    logic                  valid;
    logic [FP32_EXP_W-1:0] e;
    logic [31:0]           p;
    logic                  zero;
    logic                  nan;
  } stage2_t;

  function automatic logic [31:0] fp32_pack(input logic                  nan,
                                            input logic                  zero,
                                            input logic                  flush,
                                            input logic [FP32_EXP_W-1:0] exp_bits,
                                            input logic [FP32_MAN_W-1:0] mant);
    if (nan) return FP32_QNAN;
    if (zero || flush) return FP32_ZERO;
    return {1'b0, exp_bits, mant};
  endfunction

endpackage

// File: rtl/dequantizer_lead_one_det.sv
// Combinational leading-one detector: bit position of the highest set bit of a 32-bit word.
module lead_one_det (
  input  logic [31:0] in_i,
  output logic [4:0]  pos_o,
  output logic        found_o
);

  always_comb begin
    pos_o   = '0;
    found_o = 1'b0;
    // Ascending scan, so the highest set bit wins
    for (int i = 0; i < 32; i++) begin
      if (in_i[i]) begin
        pos_o   = 5'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dequantizer.sv
// Three-stage FP32 dequantizer: value = index * (|max| / 256), truncated toward zero.
module dequantizer
  import dequantizer_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_max,
  input  logic [IDX_W-1:0] i_index,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_value,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_busy
);

  logic             rdy_q, rdy_d;
  stage1_t          s1_q, s1_d;
  stage2_t          s2_q, s2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;
  logic             vld3_q, vld3_d;
  logic [31:0]      val3_q, val3_d;
  logic [TAG_W-1:0] tag3_q, tag3_d;

  logic adv;
  logic unused_sign;

  assign unused_sign = i_max[31];

  // Whole pipe moves as one; ready is held off for the first cycle after reset
  assign adv     = ~vld3_q | i_ready;
  assign o_ready = rdy_q & adv;

  assign rdy_d = 1'b1;

  // Stage 1: capture and classify
  logic [FP32_EXP_W-1:0] in_e;
  assign in_e = i_max[30:23];

  always_comb begin
    s1_d   = s1_q;
    tag1_d = tag1_q;
    if (adv) begin
      s1_d.valid = i_valid & o_ready;
      s1_d.idx   = i_index;
      s1_d.e     = in_e;
      s1_d.m     = {1'b1, i_max[FP32_MAN_W-1:0]};
      s1_d.zero  = (i_index == '0) | (in_e == '0);
      s1_d.nan   = (in_e == FP32_EXP_MAX);
      tag1_d     = i_tag;
    end
  end

  // Stage 2: exact integer product, fits in 32 bits since idx < 2^8 and m < 2^24
  always_comb begin
    s2_d   = s2_q;
    tag2_d = tag2_q;
    if (adv) begin
      s2_d.valid = s1_q.valid;
      s2_d.e     = s1_q.e;
      s2_d.p     = 32'(s1_q.idx) * 32'(s1_q.m);
      s2_d.zero  = s1_q.zero;
      s2_d.nan   = s1_q.nan;
      tag2_d     = tag1_q;
    end
  end

  // Stage 3: normalize and pack
  logic [4:0]            lod_pos;
  logic                  lod_found;
  logic [9:0]            re;
  logic                  flush;
  logic [31:0]           p_norm;
  logic [FP32_MAN_W-1:0] mant;
  logic [7:0]            unused_p_low;
  logic [1:0]            unused_re_high;
  logic                  unused_p_lead;

  lead_one_det u_lod (
    .in_i    (s2_q.p),
    .pos_o   (lod_pos),
    .found_o (lod_found)
  );

  always_comb begin
    re     = 10'(s2_q.e) + 10'(lod_pos) - 10'(NORM_BASE);
    flush  = re[9] | (re == '0);
    // Move the leading one to bit 31; the next 23 bits are the truncated fraction
    p_norm = s2_q.p << (5'd31 - lod_pos);
    mant   = p_norm[30:8];
  end

  assign unused_p_low   = p_norm[7:0];
  assign unused_p_lead  = p_norm[31];
  assign unused_re_high = re[9:8];

  always_comb begin
    vld3_d = vld3_q;
    val3_d = val3_q;
    tag3_d = tag3_q;
    if (adv) begin
      vld3_d = s2_q.valid;
      val3_d = fp32_pack(s2_q.nan, s2_q.zero | ~lod_found, flush, re[7:0], mant);
      tag3_d = tag2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q  <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      vld3_q <= 1'b0;
      val3_q <= FP32_ZERO;
      tag3_q <= '0;
    end else begin
      rdy_q  <= rdy_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      vld3_q <= vld3_d;
      val3_q <= val3_d;
      tag3_q <= tag3_d;
    end
  end

  assign o_valid = vld3_q;
  assign o_value = val3_q;
  assign o_tag   = tag3_q;
  assign o_busy  = s1_q.valid | s2_q.valid | vld3_q;

endmodule

// File: doc/dequantizer.md
Name: dequantizer

Overview:
- Inverse of the activation quantizer: maps an 8-bit index and the FP32 range maximum back to an FP32 activation.
- Result = index × (max / 256), truncated toward zero.
- Sits on the activation return path after index storage. Feeds downstream FP32 consumers.
- 3-stage pipeline with valid/ready handshake on both sides and a pass-through tag.

Parameters:
- TAG_W, 4, width of sideband tag carried alongside each sample.
- IDX_W, 8, index width. Fixed at 8; the divide-by-256 shift is tied to it.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream sample valid.
- o_ready  output  1  block can accept a sample this cycle.
- i_max  input  32  FP32 range maximum (same encoding the quantizer consumes).
- i_index  input  8  unsigned quantization index.
- i_tag  input  TAG_W  sideband, returned unchanged with the result.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_value  output  32  FP32 reconstructed activation.
- o_tag  output  TAG_W  tag of o_value.
- o_busy  output  1  any pipeline stage holds a valid sample.

Behaviour:
- Reset:
  - All stage valids cleared; o_valid=0, o_value=32'h0, o_tag=0, o_busy=0.
  - o_ready goes high one cycle after reset_n deasserts.
  - Reset asserted mid-operation discards all in-flight samples. No partial outputs appear after release.
- Handshake:
  - Input transfer when i_valid & o_ready. Output transfer when o_valid & i_ready.
  - adv = ~o_valid | i_ready. All three stages shift together when adv=1.
  - o_ready = adv.
  - o_valid/o_value/o_tag hold stable while o_valid=1 and i_ready=0.
- Latency and throughput:
  - Exactly 3 cycles from input transfer to o_valid when unstalled.
  - One sample per cycle sustained.
  - Bubbles are not collapsed.
- Stage 1 (capture/classify):
  - Register index, tag, e=i_max[30:23], m={1,i_max[22:0]}.
  - Flags: zero = (i_index==0) | (e==0); nan = (e==255).
  - i_max sign is ignored; |max| is used. Denormal max is treated as zero.
- Stage 2 (multiply): P = index × m, 32-bit unsigned, exact.
- Stage 3 (normalize/pack):
  - L = position of the leading one of P, 23..31.
  - re = e − 31 + L, 10-bit signed.
  - mant = P[L−1 : L−23], truncated (round toward zero, matches quantizer floor).
  - o_value = {0, re[7:0], mant}.
- Special cases (priority order):
  - nan → 32'h7FC00000.
  - zero → 32'h00000000.
  - re ≤ 0 → 32'h00000000 (flush to zero).
  - Overflow is impossible because index/256 < 1; no saturation logic.
- Output sign is always 0.
- o_busy = OR of the three stage valids.

Decomposition:
- dequantizer_pkg:
  - FP32_EXP_W=8, FP32_MAN_W=23, FP32_EXP_MAX=255.
  - IDX_W=8, IDX_SHIFT=8, NORM_BASE=31.
  - FP32_QNAN=32'h7FC00000, FP32_ZERO=32'h0.
  - Stage struct typedef: valid, tag, e, m/P, zero, nan.
- Sub-module lead_one_det:
  - 32-bit leading-one position detector, combinational, used in stage 3.
  - Returns a 5-bit position plus a found flag.

Test Plan:
- max=32'h43800000 (256), index 33/1/2/255 streamed back-to-back, i_ready=1 → o_value 32'h42040000, 3F800000, 40000000, 437F0000 on 4 consecutive cycles starting 3 cycles after the first transfer.
- max=32'h440C4000 (561), index 3 → 32'h40D26000 (6.57421875). Index 116 → 32'h437E3400 (254.203125). Index 0 → 32'h00000000.
- Special max: 32'h7F800000 (inf) with index 5 → 32'h7FC00000. Max 32'h00000001 (denormal) with index 200 → 32'h0. Max 32'hC3800000 (−256) with index 33 → 32'h42040000.
- Underflow: max=32'h00800000 (smallest normal), index 1 → re≤0 → 32'h0.
- Backpressure: stream 5 samples with distinct tags, drop i_ready for 4 cycles after the first output → o_value/o_tag held stable, o_ready=0 during the stall, no sample lost or duplicated, order preserved.
- Reset mid-stream: assert reset_n=0 while 3 samples are in flight → o_valid=0 and o_busy=0 immediately (asynchronously). After release, only newly sent samples emerge, first at 3-cycle latency.
